shreg_burst: RTL
================

SHREG_BURST -- requirements
Module: shreg_burst

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register width (>=2).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), burst count width.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  asynchronous, active-low reset.
- pdata  in  WIDTH  parallel load data.
- load  in  1  parallel load request.
- shift  in  1  single-step shift request.
- dir  in  1  shift direction: 0 = right (toward bit 0), 1 = left.
- mode  in  2  fill mode: 00 logical, 01 arithmetic, 10 rotate, 11 treated as 00.
- serial_in  in  1  serial fill bit.
- start  in  1  burst start request.
- count  in  CNT_W  number of shifts in a burst.
- qdata  out  WIDTH  register contents.
- serial_out  out  1  bit shifted out this cycle, registered.
- busy  out  1  burst in progress.
- done  out  1  one-cycle burst-complete pulse.

Function
REQ-004 SHALL use request priority load > start > shift; lower-priority requests in the same cycle are ignored.
REQ-005 SHALL load qdata <= pdata on load in the cycle after the request.
REQ-006 SHALL perform a single shift per shift request when idle, with one-cycle latency.
REQ-007 SHALL fill per mode as follows.
- Logical: vacated bit = serial_in.
- Arithmetic right: vacated MSB = old MSB.
- Arithmetic left: vacated LSB = 0.
- Rotate: vacated bit = bit shifted out.
REQ-008 SHALL drive serial_out = old qdata[0] on a right shift and old qdata[WIDTH-1] on a left shift; serial_out SHALL be 0 on every non-shift cycle.
REQ-009 SHALL implement FSM states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on start with count != 0; dir, mode and count are latched at start.
- SHIFT performs one shift per cycle using the latched dir and mode.
- SHIFT -> DONE after the count-th shift.
- DONE -> IDLE unconditionally.
REQ-010 SHALL assert busy exactly while in SHIFT and done exactly while in DONE.
REQ-011 SHALL, on start with count == 0, go IDLE -> DONE with no shift.
REQ-012 SHALL ignore start and shift while in SHIFT or DONE; live dir, mode and serial_in changes SHALL NOT affect a running burst except for the serial_in fill bit, which is sampled each cycle.
REQ-013 SHALL, on load while in SHIFT, abort the burst: qdata <= pdata and go to IDLE with no done pulse.
REQ-014 SHALL execute count values greater than WIDTH literally without clamping; rotate by WIDTH returns the original value.

Reset
REQ-015 SHALL, on reset low, immediately clear qdata = 0, serial_out = 0, busy = 0 and done = 0, with the FSM in IDLE and the internal counter at 0.
REQ-016 SHALL, on reset asserted mid-burst, abandon the burst with no done pulse after release.
REQ-017 SHALL release from reset synchronously to clk; the first operation is accepted on the first rising edge with reset high.

Configuration
REQ-018 SHALL gate rotate mode with macro SHREG_BURST_ROTATE_EN.
- Defined: mode 10 rotates per REQ-007.
- Undefined: mode 10 behaves as logical (00) and no rotate datapath is synthesised.

Structure
REQ-019 SHALL place in package shreg_pkg:
- the mode enum typedef (SHR_LOGIC, SHR_ARITH, SHR_ROT);
- the FSM state typedef;
- the direction constants DIR_RIGHT and DIR_LEFT.
REQ-020 SHALL place the FSM and down-counter in sub-module shreg_burst_ctrl, which outputs a per-cycle shift enable plus the latched dir and mode; the datapath stays in shreg_burst.

Verification
REQ-021 SHALL cover parallel load with WIDTH=16: load pdata=16'hA5C3 -> qdata=16'hA5C3 next cycle, serial_out=0.
REQ-022 SHALL cover arithmetic right burst: qdata=16'h8001, start, dir=0, mode=01, count=3 -> qdata=16'hF000 after 3 busy cycles, serial_out sequence 1,0,0, then done for 1 cycle.
REQ-023 SHALL cover rotate left burst with SHREG_BURST_ROTATE_EN: qdata=16'h8001, dir=1, mode=10, count=16 -> qdata=16'h8001 and done after 16 busy cycles; without the macro, serial_in=0 -> qdata=16'h0000.
REQ-024 SHALL cover load abort: burst count=8 running, load pdata=16'h1234 on the 3rd busy cycle -> qdata=16'h1234, busy=0 next cycle, no done pulse.
REQ-025 SHALL cover zero count and ignored shift: start with count=0 -> done pulse the next cycle, busy never 1, qdata unchanged; shift asserted during a burst -> no extra shift.
REQ-026 SHALL cover mid-burst reset: reset low during a burst -> qdata, busy, done and serial_out are 0 immediately (asynchronously); after release, shift dir=0, mode=00, serial_in=1 -> qdata=16'h8000.

Source files
------------

// File: rtl/shreg_pkg.sv
// shreg_pkg: shared mode, FSM state and direction definitions for shreg_burst
package shreg_pkg;
    typedef enum logic [1:0] {
        SHR_LOGIC = 2'b00,
        SHR_ARITH = 2'b01,
        SHR_ROT   = 2'b10
    } shr_mode_t;
    typedef logic [1:0] shr_state_t;
    localparam shr_state_t ST_IDLE  = 2'd0;
    localparam shr_state_t ST_SHIFT = 2'd1;
    localparam shr_state_t ST_DONE  = 2'd2;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/shreg_burst_ctrl.sv
// shreg_burst_ctrl: burst FSM and down-counter, issues per-cycle shift enable with the dir/mode to use
import shreg_pkg::*;

module shreg_burst_ctrl #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             start,
    input  logic             shift,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    output logic             shift_en,
    output logic             sh_dir,
    output logic [1:0]       sh_mode,
    output logic             busy,
    output logic             done
);
    shr_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic [1:0]       mode_q;

    assign busy     = state == ST_SHIFT;
    assign done     = state == ST_DONE;
    assign shift_en = !load && (busy || (state == ST_IDLE && !start && shift));
    assign sh_dir   = busy ? dir_q : dir;
    assign sh_mode  = busy ? mode_q : mode;

    // load aborts anything; start latches a burst; one shift per busy cycle until the count runs out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            dir_q  <= DIR_RIGHT;
            mode_q <= SHR_LOGIC;
        end else if (load) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                state  <= (count == '0) ? ST_DONE : ST_SHIFT;
                cnt    <= count;
                dir_q  <= dir;
                mode_q <= mode;
            end
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= ST_DONE;
        end else begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: rtl/shreg_burst.sv
// shreg_burst: shift register with single-step and burst shifting; rotate mode enabled by SHREG_BURST_ROTATE_EN
import shreg_pkg::*;

module shreg_burst #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pdata,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] qdata,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);
    logic             shift_en, sh_dir, rot, arith, so_bit, fill;
    logic [1:0]       sh_mode;
    logic [WIDTH-1:0] shifted;

    shreg_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk(clk), .reset(reset), .load(load), .start(start), .shift(shift),
        .dir(dir), .mode(mode), .count(count), .shift_en(shift_en),
        .sh_dir(sh_dir), .sh_mode(sh_mode), .busy(busy), .done(done)
    );

`ifdef SHREG_BURST_ROTATE_EN
    assign rot = sh_mode == SHR_ROT;
`else
    assign rot = 1'b0;
`endif
    assign arith   = sh_mode == SHR_ARITH;
    assign so_bit  = (sh_dir == DIR_LEFT) ? qdata[WIDTH-1] : qdata[0];
    assign fill    = rot ? so_bit : arith ? ((sh_dir == DIR_LEFT) ? 1'b0 : qdata[WIDTH-1]) : serial_in;
    assign shifted = (sh_dir == DIR_LEFT) ? {qdata[WIDTH-2:0], fill} : {fill, qdata[WIDTH-1:1]};

    // register update: parallel load wins, otherwise shift when enabled; serial_out pulses only on shifts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qdata      <= '0;
            serial_out <= 1'b0;
        end else if (load) begin
            qdata      <= pdata;
            serial_out <= 1'b0;
        end else begin
            if (shift_en) qdata <= shifted;
            serial_out <= shift_en ? so_bit : 1'b0;
        end
    end
endmodule
